count_seq_ctrl: RTL and testbench

COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

---
 rtl/count_seq_pkg.sv | 13 +
 rtl/count_seq_core.sv | 42 ++++
 rtl/count_seq_ctrl.sv | 111 +++++++++++
 tb/tb_count_seq_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the count_seq start/stop counter controller.
package count_seq_pkg;

  localparam int unsigned COUNT_SEQ_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage : count_seq_pkg

// File: rtl/count_seq_core.sv
// Up/down counter register with clear-to-zero, parallel load and hold.
module count_seq_core
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             zero_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             step_i,
  input  logic             down_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Priority: zero, then load, then step; otherwise hold. Steps wrap modulo 2^WIDTH.
  always_comb begin
    count_d = count_q;
    if (zero_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (step_i) begin
      count_d = down_i ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : count_seq_core

// File: rtl/count_seq_ctrl.sv
// Start/stop/pause controller around an up/down counter with terminal-count detect.
// Optional COUNT_SEQ_AUTORELOAD_EN: terminal cycle reloads and keeps running instead of DONE.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] limit_q, limit_d;

  logic             zero;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             step;
  logic [WIDTH-1:0] term_val;
  logic             at_term;

  // Terminal value follows the captured direction: limit going up, zero going down.
  assign term_val = dir_q ? '0 : limit_q;
  assign at_term  = (count == term_val);

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    limit_d  = limit_q;
    zero     = 1'b0;
    load     = 1'b0;
    load_val = '0;
    step     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        // stop wins over start; stop alone does nothing here
        if (!stop && start) begin
          dir_d    = dir;
          limit_d  = limit;
          load     = 1'b1;
          load_val = dir ? limit : '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end else if (at_term) begin
`ifdef COUNT_SEQ_AUTORELOAD_EN
          load     = 1'b1;
          load_val = dir_q ? limit_q : '0;
          state_d  = RUN;
`else
          state_d  = DONE;
`endif
        end else begin
          step = 1'b1;
        end
      end
      PAUSE: begin
        if (stop) begin
          zero    = 1'b1;
          state_d = IDLE;
        end else if (start) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      limit_q <= limit_d;
    end
  end

  count_seq_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk        (clk),
    .clear      (clear),
    .zero_i     (zero),
    .load_i     (load),
    .load_val_i (load_val),
    .step_i     (step),
    .down_i     (dir_q),
    .count_o    (count)
  );

  // Status flags decode directly from state and count registers.
  assign busy = (state_q == RUN) || (state_q == PAUSE);
  assign tc   = (state_q == RUN) && at_term;
  assign done = (state_q == DONE);

endmodule : count_seq_ctrl

// File: tb/tb_count_seq_ctrl.sv
// Directed self-checking bench for count_seq_ctrl (WIDTH=5); honours COUNT_SEQ_AUTORELOAD_EN.
module tb_count_seq_ctrl;

  localparam int unsigned W = 5;

  logic         clk = 1'b0;
  logic         clear;
  logic         start;
  logic         stop;
  logic         dir;
  logic [W-1:0] limit;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;
  logic         done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  count_seq_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .start (start),
    .stop  (stop),
    .dir   (dir),
    .limit (limit),
    .count (count),
    .busy  (busy),
    .tc    (tc),
    .done  (done)
  );

  // Advance one rising edge; sample point is 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int b, input int t, input int d);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".busy"},  int'(busy),  b);
    chk({tag, ".tc"},    int'(tc),    t);
    chk({tag, ".done"},  int'(done),  d);
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    dir   = 1'b0;
    limit = '0;
    #1;
    chk_all("reset_async", 0, 0, 0, 0);
    tick();
    tick();
    clear = 1'b0;
    tick();
    chk_all("reset_idle", 0, 0, 0, 0);

    // Pause and abort: limit 10 up, pause at 2, resume, pause at 4, abort.
    dir = 1'b0; limit = W'(10); start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("pa_start", 0, 1, 0, 0);
    tick();
    tick();
    chk("pa_cnt2", int'(count), 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("pa_pause", 2, 1, 0, 0);
    tick();
    chk_all("pa_hold", 2, 1, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("pa_resume", 2, 1, 0, 0);
    tick();
    chk("pa_cnt3", int'(count), 3);
    tick();
    chk("pa_cnt4", int'(count), 4);
    stop = 1'b1;
    tick();
    chk_all("pa_pause2", 4, 1, 0, 0);
    tick();
    stop = 1'b0;
    chk_all("pa_abort", 0, 0, 0, 0);

    // Simultaneous start+stop: RUN -> PAUSE, IDLE -> IDLE.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("ss_cnt1", int'(count), 1);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0;
    chk_all("ss_run_pause", 1, 1, 0, 0);
    tick();
    chk_all("ss_to_idle", 0, 0, 0, 0);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0; stop = 1'b0;
    chk_all("ss_idle_stays", 0, 0, 0, 0);

    // clear mid-run at count 3: immediate abort, no tc/done.
    dir = 1'b0; limit = W'(10); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("clr_cnt3", int'(count), 3);
    clear = 1'b1;
    #1;
    chk_all("clr_immediate", 0, 0, 0, 0);
    tick();
    chk_all("clr_held", 0, 0, 0, 0);
    clear = 1'b0;
    tick();
    chk_all("clr_released", 0, 0, 0, 0);

`ifdef COUNT_SEQ_AUTORELOAD_EN
    // Autoreload: limit 2 up wraps 0,1,2,0,1,2 with tc on each 2, never done.
    dir = 1'b0; limit = W'(2); start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("ar_0", 0, 1, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_all($sformatf("ar_%0d", k), k % 3, 1, ((k % 3) == 2) ? 1 : 0, 0);
    end
    stop = 1'b1;
    tick();
    tick();
    stop = 1'b0;
    chk_all("ar_abort", 0, 0, 0, 0);
`else
    // Up run, limit 5; dir/limit changes after start must be ignored.
    dir = 1'b0; limit = W'(5); start = 1'b1;
    tick();
    start = 1'b0; dir = 1'b1; limit = W'(9);
    chk_all("up_0", 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_all($sformatf("up_%0d", k), k, 1, (k == 5) ? 1 : 0, 0);
    end
    tick();
    chk_all("up_done", 5, 0, 0, 1);
    tick();
    chk_all("up_done_hold", 5, 0, 0, 1);

    // Down run from DONE, limit 3: 3,2,1,0 then DONE.
    dir = 1'b1; limit = W'(3); start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("dn_3", 3, 1, 0, 0);
    for (int k = 2; k >= 0; k--) begin
      tick();
      chk_all($sformatf("dn_%0d", k), k, 1, (k == 0) ? 1 : 0, 0);
    end
    tick();
    chk_all("dn_done", 0, 0, 0, 1);

    // limit 0: one tc cycle then DONE; stop alone in DONE has no effect.
    dir = 1'b0; limit = '0; start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("l0_tc", 0, 1, 1, 0);
    tick();
    chk_all("l0_done", 0, 0, 0, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_all("l0_stop_in_done", 0, 0, 0, 1);

    // limit 31 up: 32 RUN cycles, no wrap, tc only on 31.
    dir = 1'b0; limit = W'(31); start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("l31_0", 0, 1, 0, 0);
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk($sformatf("l31_cnt%0d", k), int'(count), k);
      chk($sformatf("l31_tc%0d", k), int'(tc), (k == 31) ? 1 : 0);
    end
    tick();
    chk_all("l31_done", 31, 0, 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_count_seq_ctrl
